// File: rtl/xor_or_bit_packer.sv
// Packs a one-bit-per-clock result stream into WIDTH-bit words behind two
// valid/ready handshakes, with flush of a partial word and a valid-bit count.
module xor_or_bit_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  input  logic                   flush,
  output logic [WIDTH-1:0]       word_out,
  output logic [$clog2(WIDTH):0] word_bits,
  output logic                   word_valid,
  input  logic                   word_ready
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // acc_q holds bits in arrival order (bit k = k-th arrival); placement
  // into word_out happens only when a word is loaded.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fp_q, fp_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    bits_q, bits_d;
  logic             vld_q, vld_d;

  logic             out_free, accept, load;
  logic [WIDTH-1:0] load_vec, placed;
  logic [CW-1:0]    load_bits;

  assign out_free  = !vld_q || word_ready;
  assign bit_ready = rst_n && !fp_q && !(cnt_q == LAST && !out_free);
  assign accept    = bit_valid && bit_ready;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    fp_d      = fp_q;
    word_d    = word_q;
    bits_d    = bits_q;
    vld_d     = vld_q;
    load      = 1'b0;
    load_vec  = '0;
    load_bits = '0;
    placed    = '0;

    if (accept) begin
      if (cnt_q == LAST) begin
        load      = 1'b1;
        load_vec  = {bit_in, acc_q};
        load_bits = CW'(WIDTH);
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        for (int i = 0; i < WIDTH - 1; i++)
          if (CW'(i) == cnt_q) acc_d[i] = bit_in;
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Flush sees the accumulator after this cycle's bit; a word completed
    // by that bit leaves cnt_d at zero, so the flush is a no-op.
    if ((flush || fp_q) && cnt_d != '0) begin
      if (out_free) begin
        load      = 1'b1;
        load_vec  = {1'b0, acc_d};
        load_bits = cnt_d;
        acc_d     = '0;
        cnt_d     = '0;
        fp_d      = 1'b0;
      end else begin
        fp_d = 1'b1;
      end
    end

    for (int i = 0; i < WIDTH; i++)
      placed[MSB_FIRST ? (WIDTH - 1 - i) : i] = load_vec[i];

    if (load) begin
      word_d = placed;
      bits_d = load_bits;
      vld_d  = 1'b1;
    end else if (vld_q && word_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      fp_q   <= 1'b0;
      word_q <= '0;
      bits_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      fp_q   <= fp_d;
      word_q <= word_d;
      bits_q <= bits_d;
      vld_q  <= vld_d;
    end
  end

  assign word_out   = word_q;
  assign word_bits  = bits_q;
  assign word_valid = vld_q;
endmodule

// File: tb/tb_xor_or_bit_packer.sv
// Bench for xor_or_bit_packer: MSB-first and LSB-first instances share one
// input stream and are checked against a queue-based model every cycle.
module tb_xor_or_bit_packer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n, bit_in, bit_valid, flush, word_ready;
  logic bit_ready_m, word_valid_m, bit_ready_l, word_valid_l;
  logic [W-1:0] word_out_m, word_out_l;
  logic [3:0]   word_bits_m, word_bits_l;

  always #5 clk = ~clk;

  xor_or_bit_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_m), .flush(flush), .word_out(word_out_m),
    .word_bits(word_bits_m), .word_valid(word_valid_m), .word_ready(word_ready));

  xor_or_bit_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_l), .flush(flush), .word_out(word_out_l),
    .word_bits(word_bits_l), .word_valid(word_valid_l), .word_ready(word_ready));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model, one per instance (0 = MSB first, 1 = LSB first)
  logic        mv[2];
  logic [31:0] mw[2];
  int          mb[2];
  logic        mfp[2];
  logic        mz[2];
  logic        mq[2][$];

  function automatic logic [31:0] pack(input int m, input int n);
    logic [31:0] w = 0;
    for (int k = 0; k < n; k++)
      if (mq[m][k]) w = w + (32'd1 << ((m == 0) ? (W - 1 - k) : k));
    return w;
  endfunction

  task automatic drive(input logic v, input logic b, input logic f,
                       input logic wr, input logic r);
    @(negedge clk);
    bit_valid = v; bit_in = b; flush = f; word_ready = wr; rst_n = r;
    #1;
    for (int m = 0; m < 2; m++) begin
      logic rdy_g, vld_g, out_free, rdy, ld;
      logic [31:0] wo_g, wb_g, ldw;
      int ldb;
      rdy_g = (m == 0) ? bit_ready_m : bit_ready_l;
      vld_g = (m == 0) ? word_valid_m : word_valid_l;
      wo_g  = (m == 0) ? 32'(word_out_m) : 32'(word_out_l);
      wb_g  = (m == 0) ? 32'(word_bits_m) : 32'(word_bits_l);
      out_free = !mv[m] || wr;
      rdy = r && !mfp[m] && !(mq[m].size() == W - 1 && !out_free);
      chk(m == 0 ? "m_bit_ready" : "l_bit_ready", 32'(rdy_g), 32'(rdy));
      chk(m == 0 ? "m_word_valid" : "l_word_valid", 32'(vld_g), 32'(mv[m]));
      if (mv[m] || mz[m]) begin
        chk(m == 0 ? "m_word_out" : "l_word_out", wo_g, mw[m]);
        chk(m == 0 ? "m_word_bits" : "l_word_bits", wb_g, 32'(mb[m]));
      end
      if (!r) begin
        mq[m].delete(); mv[m] = 0; mw[m] = 0; mb[m] = 0; mfp[m] = 0; mz[m] = 1;
      end else begin
        ld = 0; ldw = 0; ldb = 0;
        if (v && rdy) begin
          mq[m].push_back(b);
          if (mq[m].size() == W) begin
            ld = 1; ldw = pack(m, W); ldb = W; mq[m].delete();
          end
        end
        if ((f || mfp[m]) && mq[m].size() > 0) begin
          if (out_free) begin
            ld = 1; ldw = pack(m, mq[m].size()); ldb = mq[m].size();
            mq[m].delete(); mfp[m] = 0;
          end else mfp[m] = 1;
        end
        if (ld) begin
          mv[m] = 1; mw[m] = ldw; mb[m] = ldb; mz[m] = 0;
        end else if (mv[m] && wr) mv[m] = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] p, input logic wr);
    for (int k = 0; k < 8; k++) drive(1'b1, p[7-k], 1'b0, wr, 1'b1);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'hB2;
    bit_valid = 0; bit_in = 0; flush = 0; word_ready = 1; rst_n = 0;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; mw[m] = 0; mb[m] = 0; mfp[m] = 0; mz[m] = 0;
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    chk("rst_valid", 32'(word_valid_m), 0);
    chk("rst_word", 32'(word_out_m), 0);

    // Basic pack, both bit orders
    for (int k = 0; k < 8; k++) begin
      drive(1, pat[7-k], 0, 1, 1);
      chk("basic_ready", 32'(bit_ready_m), 1);
    end
    drive(0, 0, 0, 1, 1);
    chk("basic_msb", 32'(word_out_m), 32'hB2);
    chk("basic_lsb", 32'(word_out_l), 32'h4D);
    chk("basic_bits", 32'(word_bits_m), 8);
    chk("basic_valid", 32'(word_valid_m), 1);
    drive(0, 0, 0, 1, 1);
    chk("basic_one_cycle", 32'(word_valid_m), 0);

    // Backpressure: 0xB2 then 0xFF with consumer stalled
    for (int k = 0; k < 16; k++) begin
      drive(1, (k < 8) ? pat[7-k] : 1'b1, 0, 0, 1);
      chk("bp_ready", 32'(bit_ready_m), (k == 15) ? 0 : 1);
      if (k >= 8) chk("bp_hold", 32'(word_out_m), 32'hB2);
    end
    drive(1, 1, 0, 1, 1);
    chk("bp_handover_ready", 32'(bit_ready_m), 1);
    chk("bp_handover_word", 32'(word_out_m), 32'hB2);
    drive(0, 0, 0, 1, 1);
    chk("bp_second", 32'(word_out_m), 32'hFF);
    chk("bp_second_valid", 32'(word_valid_m), 1);
    drive(0, 0, 0, 1, 1);

    // Partial flush, then a fresh word
    drive(1, 1, 0, 1, 1); drive(1, 1, 0, 1, 1); drive(1, 0, 0, 1, 1);
    drive(0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1);
    chk("flush_msb", 32'(word_out_m), 32'hC0);
    chk("flush_lsb", 32'(word_out_l), 32'h03);
    chk("flush_bits", 32'(word_bits_m), 3);
    send_byte(pat, 1);
    drive(0, 0, 0, 1, 1);
    chk("fresh_word", 32'(word_out_m), 32'hB2);

    // Flush with empty accumulator
    drive(0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1);
    chk("flush_empty", 32'(word_valid_m), 0);

    // Flush together with the completing bit
    for (int k = 0; k < 7; k++) drive(1, 1, 0, 1, 1);
    drive(1, 1, 1, 1, 1);
    drive(0, 0, 0, 1, 1);
    chk("flush_full_bits", 32'(word_bits_m), 8);
    drive(0, 0, 0, 1, 1);
    chk("flush_full_once", 32'(word_valid_m), 0);

    // Flush while a word is held
    send_byte(pat, 0);
    drive(1, 1, 0, 0, 1); drive(1, 1, 0, 0, 1); drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    drive(1, 1, 0, 0, 1);
    chk("fp_ready_stall", 32'(bit_ready_m), 0);
    drive(1, 1, 0, 1, 1);
    chk("fp_ready_release", 32'(bit_ready_m), 0);
    chk("fp_first", 32'(word_out_m), 32'hB2);
    drive(0, 0, 0, 1, 1);
    chk("fp_partial", 32'(word_out_m), 32'hC0);
    chk("fp_partial_bits", 32'(word_bits_m), 3);
    drive(0, 0, 0, 1, 1);

    // Reset mid-operation
    send_byte(pat, 0);
    for (int k = 0; k < 5; k++) drive(1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk("rst_ready", 32'(bit_ready_m), 0);
    drive(0, 0, 0, 1, 1);
    chk("rst_mid_valid", 32'(word_valid_m), 0);
    chk("rst_mid_word", 32'(word_out_m), 0);
    chk("rst_mid_bits", 32'(word_bits_m), 0);
    send_byte(pat, 1);
    drive(0, 0, 0, 1, 1);
    chk("rst_clean", 32'(word_out_m), 32'hB2);
    drive(0, 0, 0, 1, 1);
    chk("rst_clean_once", 32'(word_valid_m), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++)
      drive($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 199) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/xor_or_bit_packer.md
# xor_or_bit_packer

Packs the single-bit result stream of the XOR/OR combinational stage (`x = (a ^ b) | c`, one bit per clock) into WIDTH-bit words for downstream logic. It sits directly downstream of that stage. It accepts bits under a valid/ready handshake and presents packed words under a second valid/ready handshake. It supports flushing a partially filled word with an explicit valid-bit count.

## Interface
- WIDTH, 8, bits per output word; legal range 2..32
- MSB_FIRST, 1, 1: the first received bit lands in word_out[WIDTH-1]; 0: it lands in word_out[0]
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset
- bit_in  input  1  data bit from the XOR/OR stage
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  packer accepts bit_in this cycle; a bit transfers when bit_valid && bit_ready
- flush  input  1  single-cycle request to close the current partial word
- word_out  output  WIDTH  packed word; unused positions are 0
- word_bits  output  $clog2(WIDTH)+1  number of valid bits in word_out (1..WIDTH)
- word_valid  output  1  word_out/word_bits hold a word
- word_ready  input  1  consumer takes the word; a word transfers when word_valid && word_ready

## Operation
- State:
  - accumulator acc (WIDTH-1 bits) with count acc_cnt (0..WIDTH-1)
  - output register (word_out, word_bits, word_valid)
  - flush_pending flag
- out_free = !word_valid || word_ready. This is combinational, so bit_ready depends on word_ready within the same cycle.
- Bit acceptance:
  - When acc_cnt < WIDTH-1, the bit is stored at the next position and acc_cnt increments.
  - When acc_cnt == WIDTH-1, the bit completes the word. acc plus the bit load into the output register with word_bits=WIDTH, and acc_cnt returns to 0.
- bit_ready = rst_n && !flush_pending && !(acc_cnt == WIDTH-1 && !out_free).
- Bit placement:
  - MSB_FIRST=1: bit k (0-based arrival order) goes to position WIDTH-1-k.
  - MSB_FIRST=0: bit k goes to position k.
- Flush:
  - Evaluated after any same-cycle bit acceptance.
  - If the resulting acc_cnt is 0 (including when the same-cycle bit completed a full word), flush has no effect.
  - Otherwise, if out_free, the partial word loads into the output register with word_bits=acc_cnt, unused positions zeroed, and acc_cnt set to 0.
  - If not out_free, flush_pending is set. bit_ready stays 0 until the partial word loads, which happens on the first cycle with out_free; flush_pending then clears.
  - flush asserted while flush_pending=1 is ignored.
- The output register holds stable while word_valid && !word_ready.
- When a word transfers and no new word loads in the same cycle, word_valid drops.
- No bit is ever dropped or duplicated. Words leave in arrival order.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - acc=0, acc_cnt=0, flush_pending=0
  - word_out=0, word_bits=0, word_valid=0
- bit_ready is 0 while rst_n is low.
- Reset mid-word discards the accumulated bits and any held word without emitting them.
- Latency: a word is accepted with its last bit (or with flush) in cycle N, and word_valid=1 from cycle N+1.
- Throughput: with word_ready held at 1, one bit per cycle indefinitely, and a WIDTH-bit word every WIDTH cycles.
- Backpressure: with word_valid=1 and word_ready=0, up to WIDTH-1 further bits are accepted. bit_ready falls when acc_cnt==WIDTH-1.
- Word handover: when word_ready rises, the stalled completing bit is accepted in that same cycle. The new word appears the next cycle with no bubble.

## Test plan
- Basic pack: WIDTH=8, MSB_FIRST=1, word_ready=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles.
  - Required: word_out=0xB2, word_bits=8, word_valid high exactly one cycle, starting the cycle after the 8th bit.
  - bit_ready stays 1 throughout.
- LSB order: same stream with MSB_FIRST=0 -> word_out=0x4D, word_bits=8.
- Backpressure: word_ready=0; offer 16 bits (0xB2 pattern, then 0xFF).
  - Required: the first word is held stable. Bits 9-15 are accepted. bit_ready=0 at the 16th bit.
  - Raise word_ready -> 0xB2 transfers, the 16th bit is accepted in the same cycle, 0xFF is valid the next cycle.
- Partial flush: bits 1,1,0, then flush -> word_out=0xC0, word_bits=3 the next cycle. The following bits start a fresh word.
- Flush corner cases:
  - flush with acc_cnt=0 -> no word.
  - flush in the same cycle as the 8th bit -> exactly one word, word_bits=8.
  - flush while word_ready=0 and a word is held -> bit_ready=0 until release; then the partial word follows the held word.
- Reset mid-operation: after 5 bits and with a held word, drive rst_n=0 for one cycle.
  - Required: word_valid=0, word_out=0, word_bits=0.
  - The next 8 bits produce exactly one clean word.
